// File: rtl/genaxis_axil_pkg.sv
// Shared types and constants for the genaxis AXI-Lite register read mux and its
// timeout counter: FSM state encoding, AXI response codes, channel-index width helper.
package genaxis_axil_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } rd_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // A single channel still needs one index bit so the decode compare has a field to look at.
    function automatic int ch_idx_w(input int ch_num);
        return (ch_num <= 1) ? 1 : $clog2(ch_num);
    endfunction

endpackage

// File: rtl/genaxis_rd_timeout.sv
// Access timeout counter: reloads to TIMEOUT-1, counts down on enabled non-stalled
// cycles and flags zero. Shared by the read side and its write-side counterpart.
module genaxis_rd_timeout #(
    parameter int TIMEOUT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    input  logic stall,
    output logic zero
);

    localparam int CNT_W = (TIMEOUT <= 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= CNT_INIT;
        end else if (load) begin
            cnt_reg <= CNT_INIT;
        end else if (en && !stall && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign zero = (cnt_reg == '0);

endmodule

// File: rtl/genaxis_axil_reg_rd_mux.sv
// AXI-Lite read slave fanning reads out to CH_NUM register read ports with ack/wait and timeout.
// Define GENAXIS_RD_ERR_EN to return DECERR/SLVERR; otherwise every response is OKAY.
module genaxis_axil_reg_rd_mux
    import genaxis_axil_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int CH_NUM        = 4,
    parameter int CH_ADDR_WIDTH = 8,
    parameter int TIMEOUT       = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [ADDR_WIDTH-1:0]        s_axil_araddr,
    input  logic [2:0]                   s_axil_arprot,
    input  logic                         s_axil_arvalid,
    output logic                         s_axil_arready,
    output logic [DATA_WIDTH-1:0]        s_axil_rdata,
    output logic [1:0]                   s_axil_rresp,
    output logic                         s_axil_rvalid,
    input  logic                         s_axil_rready,
    output logic [ADDR_WIDTH-1:0]        reg_rd_addr,
    output logic [CH_NUM-1:0]            reg_rd_en,
    input  logic [CH_NUM*DATA_WIDTH-1:0] reg_rd_data,
    input  logic [CH_NUM-1:0]            reg_rd_wait,
    input  logic [CH_NUM-1:0]            reg_rd_ack
);

    localparam int CH_IDX_W = ch_idx_w(CH_NUM);

    rd_state_t               state_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [DATA_WIDTH-1:0]   rdata_reg;
    logic                    rvalid_reg;
    logic [CH_NUM-1:0]       en_reg;

    logic [CH_IDX_W-1:0]     ar_idx;
    logic                    ar_mapped;
    logic                    ar_hs;
    logic                    sel_ack;
    logic                    sel_wait;
    logic                    to_zero;
    logic                    acc_ack;
    logic                    acc_timeout;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic [DATA_WIDTH-1:0]   masked_data [CH_NUM];
    logic                    unused_ok;

    assign unused_ok = ^s_axil_arprot;

    assign ar_idx    = s_axil_araddr[CH_ADDR_WIDTH +: CH_IDX_W];
    assign ar_mapped = ({1'b0, ar_idx} < (CH_IDX_W + 1)'(CH_NUM));
    assign ar_hs     = s_axil_arvalid && (state_reg == ST_IDLE);

    // The one-hot strobe register doubles as the channel select, so no index register is kept.
    assign sel_ack  = |(reg_rd_ack & en_reg);
    assign sel_wait = |(reg_rd_wait & en_reg);

    generate
        for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_mask
            assign masked_data[gi] = reg_rd_data[gi*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{en_reg[gi]}};
        end
    endgenerate

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            sel_data = sel_data | masked_data[i];
        end
    end

    genaxis_rd_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (ar_hs),
        .en    (state_reg == ST_ACCESS),
        .stall (sel_wait),
        .zero  (to_zero)
    );

    // Ack has priority over an expiring counter in the same cycle.
    assign acc_ack     = (state_reg == ST_ACCESS) && sel_ack;
    assign acc_timeout = (state_reg == ST_ACCESS) && !sel_ack && to_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            addr_reg   <= '0;
            rdata_reg  <= '0;
            rvalid_reg <= 1'b0;
            en_reg     <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (ar_hs) begin
                        addr_reg <= s_axil_araddr;
                        if (ar_mapped) begin
                            en_reg    <= CH_NUM'(1) << ar_idx;
                            state_reg <= ST_ACCESS;
                        end else begin
                            rdata_reg  <= '0;
                            rvalid_reg <= 1'b1;
                            state_reg  <= ST_RESP;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (acc_ack || acc_timeout) begin
                        rdata_reg  <= acc_ack ? sel_data : '0;
                        rvalid_reg <= 1'b1;
                        en_reg     <= '0;
                        state_reg  <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (s_axil_rready) begin
                        rvalid_reg <= 1'b0;
                        state_reg  <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg  <= ST_IDLE;
                    rvalid_reg <= 1'b0;
                    en_reg     <= '0;
                end
            endcase
        end
    end

`ifdef GENAXIS_RD_ERR_EN
    logic [1:0] rresp_reg;

    // Decode outcome is set at address acceptance; only a timeout can change it afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rresp_reg <= RESP_OKAY;
        end else if (ar_hs) begin
            rresp_reg <= ar_mapped ? RESP_OKAY : RESP_DECERR;
        end else if (acc_timeout) begin
            rresp_reg <= RESP_SLVERR;
        end
    end

    assign s_axil_rresp = rresp_reg;
`else
    assign s_axil_rresp = RESP_OKAY;
`endif

    assign s_axil_arready = (state_reg == ST_IDLE);
    assign s_axil_rdata   = rdata_reg;
    assign s_axil_rvalid  = rvalid_reg;
    assign reg_rd_addr    = addr_reg;
    assign reg_rd_en      = en_reg;

endmodule

// File: tb/tb_genaxis_axil_reg_rd_mux.sv
// Self-checking bench for genaxis_axil_reg_rd_mux: directed corner reads followed by
// randomized reads, each checked against a per-transaction outcome model.
module tb_genaxis_axil_reg_rd_mux;

    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int CHN = 3;
    localparam int CAW = 8;
    localparam int TO  = 4;

    logic              clk;
    logic              rst_n;
    logic [AW-1:0]     araddr;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    logic [DW-1:0]     rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;
    logic [AW-1:0]     rd_addr;
    logic [CHN-1:0]    rd_en;
    logic [CHN*DW-1:0] rd_data;
    logic [CHN-1:0]    rd_wait;
    logic [CHN-1:0]    rd_ack;

    int n_assert = 0;
    int n_fail   = 0;
    int n_txn    = 0;

    genaxis_axil_reg_rd_mux #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .CH_NUM        (CHN),
        .CH_ADDR_WIDTH (CAW),
        .TIMEOUT       (TO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .s_axil_araddr  (araddr),
        .s_axil_arprot  (arprot),
        .s_axil_arvalid (arvalid),
        .s_axil_arready (arready),
        .s_axil_rdata   (rdata),
        .s_axil_rresp   (rresp),
        .s_axil_rvalid  (rvalid),
        .s_axil_rready  (rready),
        .reg_rd_addr    (rd_addr),
        .reg_rd_en      (rd_en),
        .reg_rd_data    (rd_data),
        .reg_rd_wait    (rd_wait),
        .reg_rd_ack     (rd_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] exp_code(input logic [1:0] code);
`ifdef GENAXIS_RD_ERR_EN
        return code;
`else
        return (code == 2'b00) ? 2'b00 : 2'b00;
`endif
    endfunction

    // Drive one read. Selected channel waits for the first wait_len access cycles and acks
    // in access cycle ack_at (-1 = never); other channels toggle ack/wait randomly.
    task automatic do_read(input logic [31:0] addr, input int wait_len, input int ack_at,
                           input logic [31:0] dat, input int hold);
        int idx;
        bit mapped;
        int nonwait;
        logic [1:0] e_resp;
        logic [31:0] e_data;
        int e_en;
        int e_lat;
        logic [CHN-1:0] e_onehot;
        int cyc;
        int en_cnt;
        bit done;

        idx    = int'((addr >> CAW) & 32'h3);
        mapped = (idx < CHN);

        // Outcome from the rules: ack wins; otherwise TO-1 non-wait cycles may pass before SLVERR.
        if (!mapped) begin
            e_resp = 2'b11; e_data = '0; e_en = 0; e_lat = 1; e_onehot = '0;
        end else begin
            e_onehot = CHN'(1) << idx;
            nonwait  = 0;
            e_resp   = 2'b00; e_data = '0; e_en = 0; e_lat = 0;
            for (int c = 0; c < 1000; c++) begin
                if (c == ack_at) begin
                    e_resp = 2'b00; e_data = dat; e_en = c + 1; e_lat = c + 2;
                    break;
                end
                if (nonwait == TO - 1) begin
                    e_resp = 2'b10; e_data = '0; e_en = c + 1; e_lat = c + 2;
                    break;
                end
                if (c >= wait_len) nonwait++;
            end
        end
        e_resp = exp_code(e_resp);

        for (int i = 0; i < CHN; i++) rd_data[i*DW +: DW] = $urandom;
        if (mapped) rd_data[idx*DW +: DW] = dat;

        @(negedge clk);
        check("arready_idle", arready, 1'b1);
        araddr  = addr;
        arprot  = 3'($urandom);
        arvalid = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0;
        araddr  = $urandom;
        check("rd_addr_latch", rd_addr, addr);

        cyc = 0; en_cnt = 0; done = 0;
        while (!done && cyc < 200) begin
            if (rvalid) begin
                done = 1;
            end else begin
                if (rd_en != '0) en_cnt++;
                check("en_onehot", rd_en, e_onehot);
                rd_ack  = CHN'($urandom);
                rd_wait = CHN'($urandom);
                if (mapped) begin
                    rd_wait[idx] = (cyc < wait_len);
                    rd_ack[idx]  = (cyc == ack_at);
                end
                @(posedge clk); #1;
                cyc++;
            end
        end
        check("rvalid_bound", rvalid, 1'b1);
        rd_ack = '0; rd_wait = '0;

        check("latency", cyc + 1, e_lat);
        check("en_cycles", en_cnt, e_en);
        check("rdata", rdata, e_data);
        check("rresp", rresp, e_resp);
        check("en_off_resp", rd_en, '0);

        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("hold_rvalid", rvalid, 1'b1);
            check("hold_rdata", rdata, e_data);
            check("hold_rresp", rresp, e_resp);
            check("hold_arready", arready, 1'b0);
        end
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        check("rvalid_clear", rvalid, 1'b0);
        check("arready_after_r", arready, 1'b1);

        $display("txn %0d addr=%08h ch=%0d wait=%0d ack_at=%0d resp=%0d data=%08h lat=%0d en=%0d",
                 n_txn, addr, idx, wait_len, ack_at, rresp, rdata, cyc + 1, en_cnt);
        n_txn++;
    endtask

    initial begin
        rst_n   = 1'b0;
        araddr  = '0;
        arprot  = '0;
        arvalid = 1'b0;
        rready  = 1'b0;
        rd_data = '0;
        rd_wait = '0;
        rd_ack  = '0;

        #1;
        check("rst_arready", arready, 1'b1);
        check("rst_rvalid", rvalid, 1'b0);
        check("rst_rresp", rresp, 2'b00);
        check("rst_rdata", rdata, '0);
        check("rst_en", rd_en, '0);
        check("rst_addr", rd_addr, '0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed corners
        do_read(32'h0000_0104, 0, 0, 32'hDEADBEEF, 0);
        do_read(32'h0000_0300, 0, -1, 32'h0, 0);
        do_read(32'h0000_0000, 0, -1, 32'h5555AAAA, 0);
        do_read(32'h0000_0200, 20, 20, 32'h0000_1234, 0);
        do_read(32'h0000_0010, 0, TO - 1, 32'hCAFE_F00D, 0);
        do_read(32'h0000_0208, 0, 1, 32'h0BAD_F00D, 5);
        do_read(32'h0000_0110, 0, 0, 32'h1111_2222, 0);
        do_read(32'h0000_0304, 0, -1, 32'h0, 3);

        // Reset mid-ACCESS: selected channel stalls so the read is still pending
        @(negedge clk);
        araddr = 32'h0000_0100; arvalid = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0;
        rd_wait = '1;
        repeat (3) @(posedge clk);
        #2;
        check("mid_access_en", rd_en, 3'b010);
        rst_n = 1'b0;
        #1;
        check("rst_access_en", rd_en, '0);
        check("rst_access_rvalid", rvalid, 1'b0);
        rd_wait = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            check("post_rst_rvalid", rvalid, 1'b0);
            check("post_rst_arready", arready, 1'b1);
            check("post_rst_en", rd_en, '0);
        end

        // Reset mid-RESP with rready held low
        @(negedge clk);
        araddr = 32'h0000_0300; arvalid = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0;
        @(posedge clk); #2;
        check("mid_resp_rvalid", rvalid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst_resp_rvalid", rvalid, 1'b0);
        check("rst_resp_rdata", rdata, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst2_rvalid", rvalid, 1'b0);
        check("post_rst2_arready", arready, 1'b1);

        // Randomized reads
        for (int t = 0; t < 40; t++) begin
            logic [31:0] a;
            int ch;
            int wl;
            int ak;
            ch = int'($urandom_range(0, 3));
            a  = ($urandom & 32'hFFFF_FC00) | (32'(ch) << CAW) | ($urandom & 32'hFF);
            wl = int'($urandom_range(0, 6));
            ak = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 9));
            do_read(a, wl, ak, $urandom, int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
